// File: rtl/alu_result_bcd_serializer.sv
// ALU result to BCD digit streamer: sequential double-dabble, MSD-first valid/ready output.
// Optional ALU_BCD_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module alu_result_bcd_serializer #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [3:0]       dig_data,
    output logic             dig_last,
    output logic             dig_neg,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BW = 4 * NDIG;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    localparam longint MAXV = (longint'(1) <<< WIDTH) - 1;

    if (pow10(NDIG) <= MAXV) begin : g_bad_ndig
        $error("NDIG too small to hold 2^WIDTH-1");
    end

    function automatic logic [3:0] nib(input logic [BW-1:0] v, input int i);
        return v[4*i +: 4];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     bcd;
    logic              neg;

    logic              neg_in;
    logic [WIDTH-1:0]  mag;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_nxt;
    logic [WIDTH-1:0]  sh_nxt;
    logic [IW-1:0]     start;

    assign in_ready = rst_n && (state == IDLE);
    assign neg_in   = (in_op == 2'b01) && in_data[WIDTH-1];
    assign mag      = neg_in ? (~in_data + WIDTH'(1)) : in_data;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        {bcd_nxt, sh_nxt} = {bcd_adj, shreg} << 1;
`ifdef ALU_BCD_LEADING_ZERO_BLANK_EN
        // Highest nonzero digit wins; an all-zero value starts at digit 0.
        start = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_nxt[4*i +: 4] != 4'd0) start = IW'(i);
        end
`else
        start = IW'(NDIG - 1);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            bcd       <= '0;
            neg       <= 1'b0;
            dig_valid <= 1'b0;
            dig_data  <= 4'd0;
            dig_last  <= 1'b0;
            dig_neg   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg   <= neg_in;
                        shreg <= mag;
                        bcd   <= '0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd   <= bcd_nxt;
                    shreg <= sh_nxt;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= SEND;
                        idx       <= start;
                        dig_valid <= 1'b1;
                        dig_data  <= nib(bcd_nxt, int'(start));
                        dig_last  <= (start == '0);
                        dig_neg   <= neg;
                    end
                end
                SEND: begin
                    if (dig_ready) begin
                        if (dig_last) begin
                            state     <= IDLE;
                            dig_valid <= 1'b0;
                            dig_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            idx      <= idx - IW'(1);
                            dig_data <= nib(bcd, int'(idx) - 1);
                            dig_last <= (idx == IW'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_bcd_serializer.sv
// Self-checking bench: digit table, backpressure, mid-conversion reset, random vs model.
module tb_alu_result_bcd_serializer;

    localparam int WIDTH = 8;
    localparam int NDIG  = 3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_op;
    logic       dig_valid;
    logic       dig_ready;
    logic [3:0] dig_data;
    logic       dig_last;
    logic       dig_neg;
    logic       busy;

    alu_result_bcd_serializer #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_op(in_op),
        .dig_valid(dig_valid),
        .dig_ready(dig_ready),
        .dig_data(dig_data),
        .dig_last(dig_last),
        .dig_neg(dig_neg),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    bit exp_neg;

    typedef struct {
        logic [7:0] d;
        logic [1:0] op;
        int         h;
        int         t;
        int         o;
        bit         neg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Build expected digit list from decimal digits, honouring blanking.
    task automatic set_exp(input int h, input int t, input int o, input bit n);
        int d[3];
        bit lead;
        d[0] = h; d[1] = t; d[2] = o;
        exp_q.delete();
        lead = 1'b1;
        for (int k = 0; k < 3; k++) begin
`ifdef ALU_BCD_LEADING_ZERO_BLANK_EN
            if (lead && d[k] == 0 && k < 2) continue;
`endif
            lead = 1'b0;
            exp_q.push_back(d[k]);
        end
        exp_neg = n;
    endtask

    task automatic model(input logic [7:0] d, input logic [1:0] op);
        int v;
        bit n;
        n = (op == 2'b01) && (d >= 8'd128);
        v = n ? 256 - int'(d) : int'(d);
        set_exp(v / 100, (v / 10) % 10, v % 10, n);
    endtask

    task automatic accept(input logic [7:0] d, input logic [1:0] op);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready %0d required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall on 2nd digit + in_valid held high
    task automatic collect(input int mode);
        int cyc, got, first, stall;
        bit done, ir_bad, stab_bad, hold, hold_l, rdy;
        logic [3:0] hold_d;
        cyc = 0; got = 0; first = -1; stall = 0;
        done = 0; ir_bad = 0; stab_bad = 0; hold = 0; hold_l = 0;
        hold_d = 4'd0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (in_ready) ir_bad = 1'b1;
            if (hold && (!dig_valid || dig_data !== hold_d || dig_last !== hold_l))
                stab_bad = 1'b1;
            hold = 1'b0;
            in_valid = (mode == 2);
            in_data  = 8'h55;
            in_op    = 2'b00;
            if (dig_valid) begin
                if (first < 0) first = cyc;
                if (mode == 0) rdy = 1'b1;
                else if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
                else rdy = !(got == 1 && stall < 5);
                if (!rdy) stall++;
                dig_ready = rdy;
                if (rdy) begin
                    if (got < exp_q.size()) begin
                        chk($sformatf("digit%0d", got), int'(dig_data), exp_q[got]);
                        chk($sformatf("last%0d", got), int'(dig_last),
                            int'(got == exp_q.size() - 1));
                    end else begin
                        chk("extra_digit", got, exp_q.size() - 1);
                    end
                    chk($sformatf("neg%0d", got), int'(dig_neg), int'(exp_neg));
                    got++;
                    if (dig_last) done = 1'b1;
                end else begin
                    hold   = 1'b1;
                    hold_d = dig_data;
                    hold_l = dig_last;
                end
            end else begin
                dig_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL digit_timeout: got %0d digits required %0d", got, exp_q.size());
        end
        chk("digit_count", got, exp_q.size());
        chk("first_valid_latency", first, WIDTH + 1);
        chk("in_ready_low_while_busy", int'(ir_bad), 0);
        chk("stall_stable", int'(stab_bad), 0);
        if (mode == 2) chk("stall_cycles", stall, 5);
        @(negedge clk);
        in_valid  = 1'b0;
        dig_ready = 1'b1;
        chk("in_ready_after", int'(in_ready), 1);
        chk("busy_after", int'(busy), 0);
        chk("valid_after", int'(dig_valid), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_op     = 2'b00;
        dig_ready = 1'b1;
        vecs = '{
            '{8'd14,  2'b00, 0, 1, 4, 1'b0},
            '{8'hFD,  2'b01, 0, 0, 3, 1'b1},
            '{8'hFD,  2'b00, 2, 5, 3, 1'b0},
            '{8'd255, 2'b10, 2, 5, 5, 1'b0},
            '{8'h80,  2'b01, 1, 2, 8, 1'b1},
            '{8'd7,   2'b00, 0, 0, 7, 1'b0},
            '{8'd0,   2'b11, 0, 0, 0, 1'b0},
            '{8'd40,  2'b01, 0, 4, 0, 1'b0},
            '{8'h7F,  2'b01, 1, 2, 7, 1'b0},
            '{8'hFF,  2'b01, 0, 0, 1, 1'b1}
        };
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_dig_valid", int'(dig_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dig_last", int'(dig_last), 0);
        chk("rst_dig_neg", int'(dig_neg), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            set_exp(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].neg);
            accept(vecs[i].d, vecs[i].op);
            collect(0);
        end

        set_exp(2, 1, 3, 1'b0);
        accept(8'd213, 2'b00);
        collect(2);

        accept(8'h99, 2'b00);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_in_ready_in_reset", int'(in_ready), 0);
        chk("abort_dig_valid", int'(dig_valid), 0);
        chk("abort_busy", int'(busy), 0);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hC8;
        in_op    = 2'b01;
        #1 chk("abort_in_ready_release", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        model(8'hC8, 2'b01);
        collect(0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            logic [1:0] op;
            d  = 8'($urandom_range(0, 255));
            op = 2'($urandom_range(0, 3));
            model(d, op);
            accept(d, op);
            collect(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
